// File: rtl/hpi_responder.sv
// hpi_responder -- device-side model of the CY7C67200 HPI port.
//
// The host reaches a 2^MEM_AW x 16 word memory through a 16-bit byte-address
// register. It also sees a mailbox pair and a status word. The local side
// exposes the device end of both mailboxes.
//
// Ports
//   Clk, Reset          system clock, synchronous active-high reset
//   OTG_DATA            16-bit bidirectional bus; driven only during reads
//   OTG_ADDR            port select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   OTG_CS_N/RD_N/WR_N  active-low chip select and strobes
//   OTG_RST_N           host soft reset (memory contents survive it)
//   OTG_INT             MBX_OUT_FULL
//   mbx_in_data/valid   last host mailbox word / MBX_IN_FULL
//   mbx_in_ack          local consume strobe; clears MBX_IN_FULL
//   mbx_out_data/wr     local word for the host mailbox, one-cycle load strobe
//
// Build option: define HPI_RESP_AUTOINC_EN to post-increment the address
// register by 2 on every DATA access. Without it, DATA accesses leave the
// address unchanged.
module hpi_responder #(
  parameter int MEM_AW = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  output logic        OTG_INT,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr
);

  localparam logic [1:0] P_DATA = 2'd0, P_MBX = 2'd1, P_ADDR = 2'd2, P_STAT = 2'd3;

`ifdef HPI_RESP_AUTOINC_EN
  localparam logic [15:0] AINC = 16'd2;
`else
  localparam logic [15:0] AINC = 16'd0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_BAD} state_e;

  // The host drives the pins from Clk-synchronous flops, so one sample
  // register per pin is enough.
  logic        cs_n_q, rd_n_q, wr_n_q, rst_n_q;
  logic [1:0]  port_s_q;
  logic [15:0] wdat_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rst_n_q  <= 1'b1;
      port_s_q <= '0;
      wdat_q   <= '0;
    end else begin
      cs_n_q   <= OTG_CS_N;
      rd_n_q   <= OTG_RD_N;
      wr_n_q   <= OTG_WR_N;
      rst_n_q  <= OTG_RST_N;
      port_s_q <= OTG_ADDR;
      wdat_q   <= OTG_DATA;
    end
  end

  // Host soft reset clears everything except the memory array.
  logic clr;
  assign clr = Reset | ~rst_n_q;

  state_e      state_q, state_d;
  logic [1:0]  port_q;
  logic [15:0] addr_q, addr_d;
  logic [15:0] mbx_in_q, mbx_in_d, mbx_out_q, mbx_out_d;
  logic        in_full_q, in_full_d, out_full_q, out_full_d, ovf_q, ovf_d;
  logic [15:0] rdata_q, rdata_d;
  logic        oe_q;
  logic [15:0] mem_q;

  logic wr_go, rd_done, rd_hold, rd_mbx_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (!cs_n_q) begin
          if (!rd_n_q && !wr_n_q) state_d = S_BAD;
          else if (!rd_n_q)       state_d = S_RD;
          else if (!wr_n_q)       state_d = S_WR;
        end
      S_RD:  if (rd_n_q || cs_n_q) state_d = S_IDLE;
      S_WR:  if (wr_n_q || cs_n_q) state_d = S_IDLE;
      // Wait for a clean release so a half-raised strobe pair cannot
      // slip straight into a real access.
      S_BAD: if (cs_n_q || (rd_n_q && wr_n_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write effects fire on entry to WR; read effects fire on leaving RD.
  assign wr_go       = (state_q == S_IDLE) && (state_d == S_WR);
  assign rd_done     = (state_q == S_RD) && (state_d == S_IDLE);
  assign rd_hold     = (state_q == S_RD) && (state_d == S_RD);
  assign rd_mbx_done = rd_done && (port_q == P_MBX);

  always_comb begin
    addr_d     = addr_q;
    mbx_in_d   = mbx_in_q;
    in_full_d  = in_full_q;
    mbx_out_d  = mbx_out_q;
    out_full_d = out_full_q;
    ovf_d      = ovf_q;

    if (wr_go && port_s_q == P_ADDR)
      addr_d = wdat_q;
    else if ((wr_go && port_s_q == P_DATA) || (rd_done && port_q == P_DATA))
      addr_d = addr_q + AINC;

    // A host write in the same cycle as an ack overrides the ack.
    if (mbx_in_ack) in_full_d = 1'b0;
    if (wr_go && port_s_q == P_MBX) begin
      mbx_in_d  = wdat_q;
      in_full_d = 1'b1;
    end

    if (wr_go && port_s_q == P_STAT && wdat_q[1]) ovf_d = 1'b0;
    if (rd_mbx_done) out_full_d = 1'b0;
    // A local load in the same cycle as the host draining the mailbox
    // refills it and is not an overflow.
    if (mbx_out_wr) begin
      mbx_out_d  = mbx_out_data;
      out_full_d = 1'b1;
      if (out_full_q && !rd_mbx_done) ovf_d = 1'b1;
    end

    case (port_q)
      P_DATA:  rdata_d = mem_q;
      P_MBX:   rdata_d = mbx_out_q;
      P_ADDR:  rdata_d = addr_q;
      default: rdata_d = {7'b0, in_full_q, 6'b0, ovf_q, out_full_q};
    endcase
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      port_q     <= P_DATA;
      addr_q     <= '0;
      mbx_in_q   <= '0;
      in_full_q  <= 1'b0;
      mbx_out_q  <= '0;
      out_full_q <= 1'b0;
      ovf_q      <= 1'b0;
      rdata_q    <= '0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (state_q == S_IDLE) port_q <= port_s_q;
      addr_q     <= addr_d;
      mbx_in_q   <= mbx_in_d;
      in_full_q  <= in_full_d;
      mbx_out_q  <= mbx_out_d;
      out_full_q <= out_full_d;
      ovf_q      <= ovf_d;
      rdata_q    <= rdata_d;
      // Drive from the second RD cycle, once rdata_q holds the RAM word.
      oe_q       <= rd_hold;
    end
  end

  // Single-port RAM with a 1-cycle read. Byte bit 0 and the bits above
  // MEM_AW are dropped, so the array aliases across the 64 KiB space.
  logic [15:0]       mem [0:(1<<MEM_AW)-1];
  logic [MEM_AW-1:0] idx;
  assign idx = addr_q[MEM_AW:1];

  always_ff @(posedge Clk) begin
    if (wr_go && !clr && port_s_q == P_DATA) mem[idx] <= wdat_q;
    mem_q <= mem[idx];
  end

  assign OTG_DATA     = oe_q ? rdata_q : 16'hzzzz;
  assign OTG_INT      = out_full_q;
  assign mbx_in_valid = in_full_q;
  assign mbx_in_data  = mbx_in_q;

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: a table of host accesses plus hand-written
// sequences for mailbox races, illegal strobes and mid-read resets.
module tb_hpi_responder;

  localparam logic [1:0] P_DATA = 2'd0, P_MBX = 2'd1, P_ADDR = 2'd2, P_STAT = 2'd3;

`ifdef HPI_RESP_AUTOINC_EN
  localparam logic [15:0] W80 = 16'hA5A5;  // word 0x80 after the first two DATA writes
`else
  localparam logic [15:0] W80 = 16'h5A5A;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  wire  [15:0] OTG_DATA;
  logic [1:0]  OTG_ADDR = '0;
  logic        OTG_CS_N = 1'b1, OTG_RD_N = 1'b1, OTG_WR_N = 1'b1, OTG_RST_N = 1'b1;
  logic        OTG_INT;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack = 1'b0;
  logic [15:0] mbx_out_data = '0;
  logic        mbx_out_wr = 1'b0;

  logic        h_oe = 1'b0;
  logic [15:0] h_dat = '0;
  assign OTG_DATA = h_oe ? h_dat : 16'hzzzz;

  hpi_responder #(.MEM_AW(12)) dut (
    .Clk(Clk), .Reset(Reset), .OTG_DATA(OTG_DATA), .OTG_ADDR(OTG_ADDR),
    .OTG_CS_N(OTG_CS_N), .OTG_RD_N(OTG_RD_N), .OTG_WR_N(OTG_WR_N),
    .OTG_RST_N(OTG_RST_N), .OTG_INT(OTG_INT), .mbx_in_data(mbx_in_data),
    .mbx_in_valid(mbx_in_valid), .mbx_in_ack(mbx_in_ack),
    .mbx_out_data(mbx_out_data), .mbx_out_wr(mbx_out_wr)
  );

  always #10 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All host tasks start and end on a negedge. Strobes stay low 3 cycles,
  // then high 2 cycles so access side effects are settled on return.
  task automatic host_wr(input logic [1:0] port, input logic [15:0] d);
    OTG_CS_N = 1'b0; OTG_WR_N = 1'b0; OTG_ADDR = port; h_oe = 1'b1; h_dat = d;
    repeat (3) @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; h_oe = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic host_rd(input logic [1:0] port, output logic [15:0] d);
    OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_ADDR = port;
    repeat (3) @(negedge Clk);
    d = OTG_DATA;
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  task automatic mbx_push(input logic [15:0] d);
    mbx_out_data = d; mbx_out_wr = 1'b1;
    @(negedge Clk);
    mbx_out_wr = 1'b0;
  endtask

  typedef struct {
    logic        is_rd;
    logic [1:0]  port;
    logic [15:0] dat;   // write data, or expected read data
    string       name;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic [1:0] p, input logic [15:0] d, input string n);
    vec_t v;
    v.is_rd = r; v.port = p; v.dat = d; v.name = n;
    vt.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;

    add(1, P_STAT, 16'h0000, "stat_reset");
    add(1, P_ADDR, 16'h0000, "addr_reset");
    add(0, P_ADDR, 16'h0100, "");
    add(0, P_DATA, 16'hA5A5, "");
    add(0, P_DATA, 16'h5A5A, "");
    add(0, P_ADDR, 16'h0100, "");
`ifdef HPI_RESP_AUTOINC_EN
    add(1, P_DATA, 16'hA5A5, "data_rd0");
    add(1, P_DATA, 16'h5A5A, "data_rd1");
    add(1, P_ADDR, 16'h0104, "addr_after_rd");
    add(0, P_ADDR, 16'h0101, "");
    add(1, P_DATA, 16'hA5A5, "addr_bit0_ignored");
    add(1, P_ADDR, 16'h0103, "addr_bit0_kept");
    add(0, P_ADDR, 16'hFFFE, "");
    add(0, P_DATA, 16'h0001, "");
    add(1, P_ADDR, 16'h0000, "addr_wrap");
`else
    add(1, P_DATA, 16'h5A5A, "data_rd0");
    add(1, P_DATA, 16'h5A5A, "data_rd1");
    add(1, P_ADDR, 16'h0100, "addr_after_rd");
    add(0, P_ADDR, 16'h0101, "");
    add(1, P_DATA, 16'h5A5A, "addr_bit0_ignored");
    add(1, P_ADDR, 16'h0101, "addr_bit0_kept");
    add(0, P_ADDR, 16'hFFFE, "");
    add(0, P_DATA, 16'h0001, "");
    add(1, P_ADDR, 16'hFFFE, "addr_no_inc");
`endif
    add(0, P_ADDR, 16'h1FFE, "");
    add(1, P_DATA, 16'h0001, "alias_fff");
    add(0, P_ADDR, 16'h0FFE, "");
    add(0, P_DATA, 16'h7777, "");
    add(0, P_ADDR, 16'h2FFE, "");
    add(1, P_DATA, 16'h7777, "alias_7ff");

    // Reset state
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_int", {15'b0, OTG_INT}, 16'h0000);
    chk("rst_in_valid", {15'b0, mbx_in_valid}, 16'h0000);
    chk("rst_in_data", mbx_in_data, 16'h0000);
    h_oe = 1'b1; h_dat = 16'h0000; #1;
    chk("rst_bus_released", OTG_DATA, 16'h0000);
    h_oe = 1'b0;

    // Table of host accesses
    foreach (vt[i]) begin
      if (vt[i].is_rd) begin
        host_rd(vt[i].port, rd);
        chk(vt[i].name, rd, vt[i].dat);
      end else begin
        host_wr(vt[i].port, vt[i].dat);
      end
    end

    // Outgoing mailbox
    chk("int_before_push", {15'b0, OTG_INT}, 16'h0000);
    mbx_push(16'h1234);
    chk("int_after_push", {15'b0, OTG_INT}, 16'h0001);
    host_rd(P_STAT, rd);   chk("stat_out_full", rd, 16'h0001);
    host_rd(P_MBX, rd);    chk("mbx_out_rd", rd, 16'h1234);
    chk("int_cleared", {15'b0, OTG_INT}, 16'h0000);

    // Overflow and its clear
    mbx_push(16'h1111);
    mbx_push(16'h2222);
    host_rd(P_STAT, rd);   chk("stat_ovf", rd, 16'h0003);
    host_wr(P_STAT, 16'h0002);
    host_rd(P_STAT, rd);   chk("stat_ovf_clr", rd, 16'h0001);
    host_rd(P_MBX, rd);    chk("mbx_out_last", rd, 16'h2222);
    host_rd(P_STAT, rd);   chk("stat_empty", rd, 16'h0000);

    // Incoming mailbox
    host_wr(P_MBX, 16'hBEEF);
    chk("in_valid", {15'b0, mbx_in_valid}, 16'h0001);
    chk("in_data", mbx_in_data, 16'hBEEF);
    host_rd(P_STAT, rd);   chk("stat_in_full", rd, 16'h0100);
    mbx_in_ack = 1'b1;
    @(negedge Clk);
    mbx_in_ack = 1'b0;
    chk("in_acked", {15'b0, mbx_in_valid}, 16'h0000);

    // Ack in the same cycle as a host mailbox write: the write wins
    OTG_CS_N = 1'b0; OTG_WR_N = 1'b0; OTG_ADDR = P_MBX; h_oe = 1'b1; h_dat = 16'hCAFE;
    @(negedge Clk);
    mbx_in_ack = 1'b1;
    @(negedge Clk);
    mbx_in_ack = 1'b0;
    @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_WR_N = 1'b1; h_oe = 1'b0;
    repeat (2) @(negedge Clk);
    chk("ack_vs_wr_valid", {15'b0, mbx_in_valid}, 16'h0001);
    chk("ack_vs_wr_data", mbx_in_data, 16'hCAFE);
    mbx_in_ack = 1'b1;
    @(negedge Clk);
    mbx_in_ack = 1'b0;

    // Local load in the same cycle as the host mailbox read completing
    mbx_push(16'hAAAA);
    OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_ADDR = P_MBX;
    repeat (3) @(negedge Clk);
    chk("race_rd_data", OTG_DATA, 16'hAAAA);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    @(negedge Clk);
    mbx_out_data = 16'hBBBB; mbx_out_wr = 1'b1;
    @(negedge Clk);
    mbx_out_wr = 1'b0;
    chk("race_int", {15'b0, OTG_INT}, 16'h0001);
    host_rd(P_STAT, rd);   chk("race_no_ovf", rd, 16'h0001);
    host_rd(P_MBX, rd);    chk("race_new_word", rd, 16'hBBBB);

    // Both strobes low: no drive, no side effects
    host_wr(P_ADDR, 16'h0100);
    OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_WR_N = 1'b0; OTG_ADDR = P_DATA;
    h_oe = 1'b1; h_dat = 16'h0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      chk("bad_no_drive", OTG_DATA, 16'h0000);
    end
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1; h_oe = 1'b0;
    repeat (2) @(negedge Clk);
    host_rd(P_ADDR, rd);   chk("bad_addr_same", rd, 16'h0100);
    host_rd(P_DATA, rd);   chk("bad_mem_same", rd, W80);

    // Reset mid-read
    mbx_push(16'h5555);
    host_wr(P_ADDR, 16'h0100);
    OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_ADDR = P_DATA;
    repeat (3) @(negedge Clk);
    chk("rst_rd_driven", OTG_DATA, W80);
    Reset = 1'b1; h_oe = 1'b1; h_dat = 16'h0000;
    @(negedge Clk);
    chk("rst_rd_released", OTG_DATA, 16'h0000);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; h_oe = 1'b0;
    @(negedge Clk);
    chk("rst_int_clr", {15'b0, OTG_INT}, 16'h0000);
    host_rd(P_ADDR, rd);   chk("rst_addr_zero", rd, 16'h0000);
    host_wr(P_ADDR, 16'h0100);
    host_rd(P_DATA, rd);   chk("rst_mem_kept", rd, W80);

    // Host soft reset mid-read
    mbx_push(16'h6666);
    host_wr(P_MBX, 16'h7777);
    host_wr(P_ADDR, 16'h0100);
    OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_ADDR = P_DATA;
    repeat (3) @(negedge Clk);
    chk("srst_rd_driven", OTG_DATA, W80);
    OTG_RST_N = 1'b0;
    @(negedge Clk);
    OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; h_oe = 1'b1; h_dat = 16'h0000;
    @(negedge Clk);
    chk("srst_released", OTG_DATA, 16'h0000);
    OTG_RST_N = 1'b1; h_oe = 1'b0;
    repeat (2) @(negedge Clk);
    chk("srst_int_clr", {15'b0, OTG_INT}, 16'h0000);
    chk("srst_in_valid", {15'b0, mbx_in_valid}, 16'h0000);
    chk("srst_in_data", mbx_in_data, 16'h0000);
    host_rd(P_ADDR, rd);   chk("srst_addr_zero", rd, 16'h0000);
    host_wr(P_ADDR, 16'h0100);
    host_rd(P_DATA, rd);   chk("srst_mem_kept", rd, W80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hpi_responder.md
# hpi_responder

Device-side responder for the 16-bit HPI bus that the host-side `hpi_io_intf` drives toward the EZ-OTG chip. It models the CY7C67200 HPI port: a word memory reached through an auto-incrementing byte-address register, a mailbox pair and a status register. It stands in for the chip in full-system simulation and can be dropped into an FPGA-to-FPGA loopback build. Sits on the OTG_* pins; its local side exposes the device end of both mailboxes.

## Interface
- `MEM_AW`, default 12: word-address width of the internal memory (2^MEM_AW × 16 bits).
- `Clk` in 1: system clock, 50 MHz.
- `Reset` in 1: synchronous, active-high reset.
- `OTG_DATA` inout 16: HPI data bus; driven only during a read access, else `'z`.
- `OTG_ADDR` in 2: port select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- `OTG_CS_N` in 1: chip select, active low.
- `OTG_RD_N` in 1: read strobe, active low.
- `OTG_WR_N` in 1: write strobe, active low.
- `OTG_RST_N` in 1: host-driven soft reset, active low.
- `OTG_INT` out 1: interrupt to host, active high, equals MBX_OUT_FULL.
- `mbx_in_data` out 16: last host-written mailbox word.
- `mbx_in_valid` out 1: MBX_IN_FULL.
- `mbx_in_ack` in 1: local side consumed mbx_in; clears MBX_IN_FULL.
- `mbx_out_data` in 16: word for the host mailbox.
- `mbx_out_wr` in 1: one-cycle strobe loading mbx_out_data.

## Operation
- All OTG_* inputs are sampled on posedge Clk. Sampling is single-register, because the host drives them from Clk-synchronous flops.
- Access FSM states:
  - IDLE to RD when CS_N=0, RD_N=0, WR_N=1.
  - IDLE to WR when CS_N=0, WR_N=0, RD_N=1.
  - IDLE to BAD when both strobes are low. BAD is a no-op: no drive and no side effects. It returns to IDLE when either the strobes or CS_N deassert.
  - RD returns to IDLE when RD_N or CS_N rises. WR returns to IDLE when WR_N or CS_N rises.
- Write effects apply once, on the IDLE to WR transition:
  - DATA: mem[addr[MEM_AW:1]] ← data, then addr += 2.
  - MAILBOX: mbx_in ← data; MBX_IN_FULL ← 1.
  - ADDRESS: addr ← data.
  - STATUS: writing 1 to bit 1 clears MBX_OVF. Other bits are ignored.
- Read data per port:
  - DATA: mem[addr[MEM_AW:1]].
  - MAILBOX: mbx_out.
  - ADDRESS: addr.
  - STATUS: {7'b0, MBX_IN_FULL, 6'b0, MBX_OVF, MBX_OUT_FULL}.
- Read side effects apply once, on the RD to IDLE transition:
  - DATA: addr += 2.
  - MAILBOX: MBX_OUT_FULL ← 0.
- Addr is 16-bit and wraps 0xFFFE to 0x0000. Address bits above MEM_AW are ignored, so memory aliases. Addr bit 0 is stored but ignored for memory indexing.
- `mbx_out_wr`: mbx_out ← mbx_out_data and MBX_OUT_FULL ← 1. If MBX_OUT_FULL was already 1, MBX_OVF ← 1 as well.
- Simultaneous events:
  - mbx_out_wr in the same cycle as a host MAILBOX read completing: the write wins, MBX_OUT_FULL stays 1 and MBX_OVF is not set.
  - mbx_in_ack in the same cycle as a host MAILBOX write: the write wins, MBX_IN_FULL stays 1.
- `OTG_RST_N`=0, sampled: acts as Reset for every register except memory. Memory contents are never cleared.
- Reset values: FSM IDLE, addr 0, mbx_in 0, mbx_out 0, all flags 0, OTG_INT 0, OTG_DATA `'z`, mbx_in_valid 0, mbx_in_data 0.
- A Reset or OTG_RST_N during an access aborts it: the bus is released the next cycle and pending side effects are dropped.

## Timing
- Read latency: OTG_DATA is valid and driven starting at the 2nd posedge after the edge on which CS_N=0 and RD_N=0 are first sampled. It holds, from registered read data, until the cycle after RD_N or CS_N is sampled high.
- A read returns pre-access state: the increment happens after the access.
- Write effects are visible to a following access that starts ≥1 cycle after WR_N is sampled high.
- Minimum strobe low time: 3 Clk cycles. Minimum high time between accesses: 1 cycle.
- OTG_INT and mbx_in_valid are registered, with 1-cycle latency from the causing event.
- Memory is a single-port synchronous RAM with 1-cycle read.

## Configuration
- `HPI_RESP_AUTOINC_EN`
  - Defined: DATA reads and writes post-increment addr by 2, as described above.
  - Undefined: addr changes only on ADDRESS writes and resets. Repeated DATA accesses hit the same word.
  - All other behaviour is identical in both cases.

## Test plan
- Write ADDRESS=0x0100, DATA 0xA5A5, DATA 0x5A5A; write ADDRESS=0x0100; read DATA twice -> 0xA5A5 then 0x5A5A; final ADDRESS read -> 0x0104 (0x0100 without macro, with second read 0x5A5A written over… expects 0x5A5A both reads).
- mbx_out_wr with 0x1234 -> OTG_INT=1 one cycle later; STATUS read=0x0001; MAILBOX read -> 0x1234, OTG_INT=0 after RD_N rises.
- Two mbx_out_wr without a host read -> STATUS=0x0003; write STATUS 0x0002 -> STATUS=0x0001.
- Host writes MAILBOX 0xBEEF -> mbx_in_valid=1, mbx_in_data=0xBEEF, STATUS=0x0100; mbx_in_ack -> 0; ack in the same cycle as a new write -> valid stays 1.
- Write ADDRESS=0xFFFE, DATA 0x0001 -> ADDRESS reads 0x0000; with MEM_AW=12, ADDRESS=0x1FFE aliases word 0xFFF.
- Both strobes low -> OTG_DATA stays `'z` and state is unchanged. OTG_RST_N or Reset mid-read -> bus released next cycle, addr=0, memory preserved.
